conv_layer_p: RTL and testbench

CONV_LAYER_P -- requirements
Module: conv_layer_p

---
 rtl/conv_layer_p_if.sv | 33 +++
 rtl/conv_layer_p.sv | 141 ++++++++++++++
 tb/tb_conv_layer_p.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_p_if.sv
// Bus bundle for conv_layer_p: weight-load port, window handshake and result.
//
// Handshake: a window transfers on a rising edge where in_valid and in_ready
// are both high; in_valid with in_ready low is simply dropped, never held.
// out_valid is a one-cycle qualifier with no back-pressure; result holds its
// value between qualifiers.
interface conv_layer_p_if #(
  parameter int BIT_DEPTH = 16,
  parameter int NW        = 27
) ();
  logic                    w_start;
  logic                    w_valid;
  logic [BIT_DEPTH-1:0]    w_data;
  logic                    w_done;
  logic                    in_valid;
  logic [BIT_DEPTH*NW-1:0] in;
  logic                    in_ready;
  logic                    relu_en;
  logic [BIT_DEPTH-1:0]    result;
  logic                    out_valid;

  // Stimulus / upstream side
  modport master (
    output w_start, w_valid, w_data, in_valid, in, relu_en,
    input  w_done, in_ready, result, out_valid
  );

  // Convolution block side
  modport slave (
    input  w_start, w_valid, w_data, in_valid, in, relu_en,
    output w_done, in_ready, result, out_valid
  );
endinterface

// File: rtl/conv_layer_p.sv
// Multi-channel 3x3 convolution point: loads N_CH*KSIZE signed weights, then
// computes one saturated (optionally ReLU'd) dot product per accepted window
// through a 3-register pipeline (products, sum, result).
module conv_layer_p #(
  parameter int BIT_DEPTH = 16,
  parameter int KSIZE     = 9,
  parameter int N_CH      = 3,
  parameter int FRAC      = 0
) (
  input  logic                clk,
  input  logic                RESET,
  conv_layer_p_if.slave       bus,
  output logic [1:0]          state_dbg
);
  localparam int NW = N_CH * KSIZE;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = 2 * BIT_DEPTH;
  localparam int SW = PW + $clog2(NW);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
  localparam logic signed [SW-1:0] MAX_V =
    {{(SW-BIT_DEPTH+1){1'b0}}, {(BIT_DEPTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V =
    {{(SW-BIT_DEPTH+1){1'b1}}, {(BIT_DEPTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;

  state_t state, state_n;

  logic [IW-1:0]                idx;
  logic signed [BIT_DEPTH-1:0]  weight [NW];
  logic signed [BIT_DEPTH-1:0]  samp   [NW];
  logic signed [PW-1:0]         prod_q [NW];
  logic                         v1, v2;
  logic                         relu1, relu2;
  logic signed [SW-1:0]         sum_c, sum_q, shifted;
  logic signed [BIT_DEPTH-1:0]  res_c;
  logic                         accept, w_write, load_entry;

  assign bus.in_ready = (state == READY);
  assign accept       = bus.in_valid && bus.in_ready;
  assign w_write      = (state == LOAD) && bus.w_valid;
  assign load_entry   = (state != LOAD) && (state_n == LOAD);
  assign state_dbg    = state;

  // FSM state register
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: w_start is only honoured outside LOAD
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.w_start) state_n = LOAD;
      LOAD:    if (w_write && idx == LAST_IDX) state_n = READY;
      READY:   if (bus.w_start) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  // Weight index, weight store and load-complete pulse
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      idx        <= '0;
      bus.w_done <= 1'b0;
      for (int k = 0; k < NW; k++) weight[k] <= '0;
    end else begin
      bus.w_done <= w_write && (idx == LAST_IDX);
      if (load_entry) begin
        idx <= '0;
      end else if (w_write) begin
        weight[idx] <= bus.w_data;
        idx         <= idx + 1'b1;
      end
    end
  end

  // Slice the flat window: sample 0 sits in the most significant lane
  always_comb begin
    for (int k = 0; k < NW; k++)
      samp[k] = bus.in[BIT_DEPTH*(NW-k)-1 -: BIT_DEPTH];
  end

  // Stage 1: register every product so a weight reload cannot disturb it
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      v1    <= 1'b0;
      relu1 <= 1'b0;
      for (int k = 0; k < NW; k++) prod_q[k] <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        relu1 <= bus.relu_en;
        for (int k = 0; k < NW; k++) prod_q[k] <= samp[k] * weight[k];
      end
    end
  end

  // Adder tree, wide enough that NW full-scale products cannot overflow
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NW; k++)
      sum_c = sum_c + {{(SW-PW){prod_q[k][PW-1]}}, prod_q[k]};
  end

  // Stage 2: register the sum
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      v2    <= 1'b0;
      relu2 <= 1'b0;
      sum_q <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sum_q <= sum_c;
        relu2 <= relu1;
      end
    end
  end

  // Scale (floor), saturate, then optional ReLU
  always_comb begin
    shifted = sum_q >>> FRAC;
    if (shifted > MAX_V)      res_c = MAX_V[BIT_DEPTH-1:0];
    else if (shifted < MIN_V) res_c = MIN_V[BIT_DEPTH-1:0];
    else                      res_c = shifted[BIT_DEPTH-1:0];
    if (relu2 && res_c[BIT_DEPTH-1]) res_c = '0;
  end

  // Output stage: result holds between valid cycles
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
    end else begin
      bus.out_valid <= v2;
      if (v2) bus.result <= res_c;
    end
  end
endmodule

// File: tb/tb_conv_layer_p.sv
// Self-checking bench for conv_layer_p with BIT_DEPTH=16, KSIZE=9, N_CH=3.
module tb_conv_layer_p;
  localparam int NW = 27;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic RESET;
  logic [1:0] state_dbg;

  conv_layer_p_if #(.BIT_DEPTH(BD), .NW(NW)) bus ();

  conv_layer_p #(.BIT_DEPTH(BD), .KSIZE(9), .N_CH(3), .FRAC(0)) dut (
    .clk(clk), .RESET(RESET), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;
  int wdone_cnt = 0;

  logic [BD-1:0] exp_q[$];
  int            cyc_q[$];

  logic signed [BD-1:0] wts [NW];
  logic signed [BD-1:0] win [NW];

  // ---------------- reference model ----------------
  function automatic logic [BD-1:0] model(input bit relu);
    longint acc = 0;
    for (int k = 0; k < NW; k++) acc += longint'(win[k]) * longint'(wts[k]);
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return acc[BD-1:0];
  endfunction

  function automatic logic [BD*NW-1:0] pack();
    logic [BD*NW-1:0] r;
    r = '0;
    for (int k = 0; k < NW; k++) r[BD*(NW-k)-1 -: BD] = win[k];
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.w_done) wdone_cnt++;
    if (RESET && bus.out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: result=%h cycle=%0d, no output required", bus.result, cyc);
      end else begin
        logic [BD-1:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        if (bus.result !== e || cyc != c) begin
          bad++;
          $display("FAIL result: got %h at cycle %0d, required %h at cycle %0d", bus.result, cyc, e, c);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights();
    bus.w_start = 1'b1;
    step();
    bus.w_start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = wts[i];
      step();
    end
    bus.w_valid = 1'b0;
    total++;
    if (bus.w_done !== 1'b1 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_done: w_done=%b in_ready=%b, required 1 1", bus.w_done, bus.in_ready);
    end
    step();
    total++;
    if (bus.w_done !== 1'b0) begin
      bad++;
      $display("FAIL w_done_pulse: w_done=%b, required 0", bus.w_done);
    end
  endtask

  // Drive one window this cycle; it is accepted on the next edge
  task automatic send_window(input bit relu);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL in_ready_before_send: in_ready=%b, required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in       = pack();
    bus.relu_en  = relu;
    exp_q.push_back(model(relu));
    cyc_q.push_back(cyc + 3);
    step();
    bus.in_valid = 1'b0;
    bus.relu_en  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b0;
    bus.w_start = 0; bus.w_valid = 0; bus.w_data = '0;
    bus.in_valid = 0; bus.in = '0; bus.relu_en = 0;
    repeat (3) step();
    total++;
    if (bus.in_ready !== 1'b0 || bus.w_done !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.result !== 16'h0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b wd=%b ov=%b res=%h st=%0d, required all 0",
               bus.in_ready, bus.w_done, bus.out_valid, bus.result, state_dbg);
    end
    RESET = 1'b1;
    step();
    total++;
    if (bus.in_ready !== 1'b0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL idle_after_reset: in_ready=%b st=%0d, required 0 0", bus.in_ready, state_dbg);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < NW; k++) begin wts[k] = 16'sd1; win[k] = 16'sd2; end
    load_weights();
    send_window(1'b0);  // expects 54
    drain();
  endtask

  task automatic test_mixed_back_to_back();
    for (int k = 0; k < NW; k++) begin
      wts[k] = (k <= 13) ? 16'sd3 : 16'sd1;
      win[k] = 16'sd1;
    end
    load_weights();
    send_window(1'b0);  // expects 55
    // stray weight writes in READY must not disturb the kernel
    for (int i = 0; i < 3; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = 16'h1234;
      step();
    end
    bus.w_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < NW; k++) win[k] = 16'($urandom_range(0, 65535)) >>> 4;
      send_window(n[0]);
    end
    drain();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < NW; k++) begin wts[k] = 16'sh7FFF; win[k] = 16'sh7FFF; end
    load_weights();
    send_window(1'b0);  // expects 7FFF
    drain();
    for (int k = 0; k < NW; k++) wts[k] = 16'sh8000;
    load_weights();
    send_window(1'b0);  // expects 8000
    drain();
  endtask

  task automatic test_relu_and_hold();
    for (int k = 0; k < NW; k++) begin wts[k] = -16'sd1; win[k] = 16'sd1; end
    load_weights();
    send_window(1'b1);  // expects 0
    send_window(1'b0);  // expects FFE5
    drain();
    repeat (3) step();
    total++;
    if (bus.result !== 16'hFFE5 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL result_hold: result=%h ov=%b, required ffe5 0", bus.result, bus.out_valid);
    end
  endtask

  task automatic test_reset_midload();
    bus.w_start = 1'b1;
    step();
    bus.w_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = 16'sd5;
      step();
    end
    RESET = 1'b0;
    bus.w_valid = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.w_done !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.result !== 16'h0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL async_reset: rdy=%b wd=%b ov=%b res=%h st=%0d, required all 0",
               bus.in_ready, bus.w_done, bus.out_valid, bus.result, state_dbg);
    end
    step();
    RESET = 1'b1;
    wdone_cnt = 0;
    // windows offered before a fresh load must be dropped
    for (int k = 0; k < NW; k++) win[k] = 16'sd1;
    bus.in = pack();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_before_load: in_ready=%b, required 0", bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < NW; k++) wts[k] = 16'(k) - 16'sd13;
    load_weights();
    repeat (2) step();
    total++;
    if (wdone_cnt != 1) begin
      bad++;
      $display("FAIL w_done_count: %0d pulses, required 1", wdone_cnt);
    end
    for (int k = 0; k < NW; k++) win[k] = 16'sd7 - 16'(k % 5);
    send_window(1'b0);
    drain();
  endtask

  task automatic test_inflight_reload();
    for (int k = 0; k < NW; k++) begin
      wts[k] = 16'sd2;
      win[k] = 16'(k + 1);
    end
    load_weights();
    // window accepted on the same edge that w_start moves the FSM to LOAD
    bus.w_start = 1'b1;
    send_window(1'b0);  // result uses old weights (756)
    bus.w_start = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0 || state_dbg !== 2'd1) begin
      bad++;
      $display("FAIL enter_load: in_ready=%b st=%0d, required 0 1", bus.in_ready, state_dbg);
    end
    // new weights stream in while in_valid is held high and must be dropped
    for (int k = 0; k < NW; k++) wts[k] = 16'($urandom_range(0, 200)) - 16'sd100;
    bus.in_valid = 1'b1;
    bus.in = pack();
    for (int i = 0; i < NW; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = wts[i];
      step();
    end
    bus.w_valid  = 1'b0;
    bus.in_valid = 1'b0;
    step();
    drain();
    for (int k = 0; k < NW; k++) win[k] = 16'($urandom_range(0, 400)) - 16'sd200;
    send_window(1'b0);
    send_window(1'b1);
    drain();
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_basic();
    test_mixed_back_to_back();
    test_saturation();
    test_relu_and_hold();
    test_reset_midload();
    test_inflight_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
